// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM state encoding,
// default bus widths and the starvation-counter width helper.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FORCE = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

  // Bits needed to hold 0..limit inclusive: ceil(log2(limit+1)).
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_timer.sv
// Saturating count of consecutive denied debug cycles. The count clears on
// any grant or on any cycle without a request. expire flags the denial that
// brings the count to STARVE_LIMIT, so the next cycle can be a forced slot.
module starve_timer
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic expire
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STARVE_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             denied;

  assign denied = req & ~gnt;
  assign expire = denied & (cnt_q == LAST);

  // Next count: clear unless denied, otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!denied) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter between the MEM stage and a debug/loader port.
// The CPU has priority; debug is served on cycles where the MEM stage does
// not touch memory. With DMEM_ARB_FAIR_EN defined, a starvation timer forces
// a one-cycle debug slot and freezes the pipeline via cpu_stall. Without it,
// CPU priority is strict and cpu_stall stays low.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_active,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_spo
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
  end

  logic              force_slot;
  logic              gnt;
  logic              stall;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

`ifdef DMEM_ARB_FAIR_EN
  arb_state_e state_q, state_d;
  logic       expire;

  starve_timer #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .req   (dbg_req),
    .gnt   (gnt),
    .expire(expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a forced slot lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (expire) state_d = FORCE;
      FORCE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign force_slot = (state_q == FORCE);
`else
  assign force_slot = 1'b0;
`endif

  // Grant decision; a forced slot pre-empts the CPU and stalls it if active.
  always_comb begin
    gnt   = 1'b0;
    stall = 1'b0;
    if (!reset) begin
      if (force_slot && dbg_req) begin
        gnt   = 1'b1;
        stall = cpu_mem_active;
      end else if (!cpu_mem_active && dbg_req) begin
        gnt   = 1'b1;
      end
    end
  end

  // RAM pin mux; all pins idle at zero while in reset.
  always_comb begin
    ram_a  = '0;
    ram_d  = '0;
    ram_we = 1'b0;
    if (!reset) begin
      if (gnt) begin
        ram_a  = dbg_addr;
        ram_d  = dbg_wdata;
        ram_we = dbg_we;
      end else begin
        ram_a  = cpu_addr;
        ram_d  = cpu_wdata;
        ram_we = cpu_we & cpu_mem_active;
      end
    end
  end

  // Capture debug read data at the grant edge; rvalid pulses for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt & ~dbg_we;
      if (gnt && !dbg_we) begin
        rdata_q <= ram_spo;
      end
    end
  end

  assign dbg_gnt    = gnt;
  assign cpu_stall  = stall;
  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rdata_q;
  assign cpu_rdata  = ram_spo;

endmodule
